// File: rtl/ifetch_unit.sv
// Instruction fetch stage of the single-cycle MIPS datapath: program counter,
// ROM addressing, instruction field split and next-PC selection.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ROM_ADDR_W = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    output logic [ROM_ADDR_W-1:0] rom_adr,
    input  logic [31:0]           rom_data,
    output logic [31:0]           Instruction,
    output logic [5:0]            Exe_opcode,
    output logic [5:0]            Function_opcode,
    output logic [4:0]            Shamt,
    output logic [31:0]           PC,
    output logic [31:0]           PC_plus_4,
    input  logic [31:0]           Addr_Result,
    input  logic                  Zero,
    input  logic [31:0]           Read_data_1,
    input  logic                  Branch,
    input  logic                  nBranch,
    input  logic                  Jmp,
    input  logic                  Jal,
    input  logic                  Jr,
    output logic [31:0]           link_addr,
    output logic [31:0]           inst_count
);

    logic [31:0] pc_r;
    logic [31:0] link_addr_r;
    logic [31:0] inst_count_r;
    logic [31:0] pc_plus_4_s;
    logic [31:0] jump_target_s;
    logic [31:0] jr_target_s;
    logic [31:0] next_pc_s;
    logic        taken_s;

    assign pc_plus_4_s   = pc_r + 32'd4;
    assign jump_target_s = {pc_plus_4_s[31:28], rom_data[25:0], 2'b00};
    assign jr_target_s   = {Read_data_1[31:2], 2'b00};
    assign taken_s       = (Branch & Zero) | (nBranch & ~Zero);

    // Next-PC mux; Jr outranks jumps, which outrank conditional branches.
    always_comb begin
        next_pc_s = pc_plus_4_s;
        if (Jr) begin
            next_pc_s = jr_target_s;
        end else if (Jmp | Jal) begin
            next_pc_s = jump_target_s;
        end else if (taken_s) begin
            next_pc_s = Addr_Result;
        end else begin
            next_pc_s = pc_plus_4_s;
        end
    end

    // PC, return-address and retired-instruction registers; reset beats stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r         <= RESET_PC;
            link_addr_r  <= 32'h0000_0000;
            inst_count_r <= 32'h0000_0000;
        end else if (stall) begin
            pc_r         <= pc_r;
            link_addr_r  <= link_addr_r;
            inst_count_r <= inst_count_r;
        end else begin
            pc_r         <= next_pc_s;
            inst_count_r <= inst_count_r + 32'd1;
            if (Jal) begin
                link_addr_r <= pc_plus_4_s;
            end else begin
                link_addr_r <= link_addr_r;
            end
        end
    end

    // Out-of-range PCs alias into the ROM by dropping the upper bits.
    assign rom_adr         = pc_r[ROM_ADDR_W+1:2];
    assign Instruction     = rom_data;
    assign Exe_opcode      = rom_data[31:26];
    assign Function_opcode = rom_data[5:0];
    assign Shamt           = rom_data[10:6];
    assign PC              = pc_r;
    assign PC_plus_4       = pc_plus_4_s;
    assign link_addr       = link_addr_r;
    assign inst_count      = inst_count_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit.
module tb_ifetch_unit;

    logic        clock = 1'b0;
    logic        reset, stall;
    logic [13:0] rom_adr;
    logic [31:0] rom_data, Instruction, PC, PC_plus_4, Addr_Result, Read_data_1;
    logic [31:0] link_addr, inst_count;
    logic [5:0]  Exe_opcode, Function_opcode;
    logic [4:0]  Shamt;
    logic        Zero, Branch, nBranch, Jmp, Jal, Jr;

    int passed = 0;
    int total  = 0;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .ROM_ADDR_W(14)) dut (
        .clock(clock), .reset(reset), .stall(stall), .rom_adr(rom_adr),
        .rom_data(rom_data), .Instruction(Instruction), .Exe_opcode(Exe_opcode),
        .Function_opcode(Function_opcode), .Shamt(Shamt), .PC(PC),
        .PC_plus_4(PC_plus_4), .Addr_Result(Addr_Result), .Zero(Zero),
        .Read_data_1(Read_data_1), .Branch(Branch), .nBranch(nBranch),
        .Jmp(Jmp), .Jal(Jal), .Jr(Jr), .link_addr(link_addr),
        .inst_count(inst_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctl();
        Branch = 1'b0; nBranch = 1'b0; Jmp = 1'b0; Jal = 1'b0; Jr = 1'b0;
        Zero = 1'b0; stall = 1'b0;
    endtask

    // Jump to an arbitrary PC through jr, then release the controls.
    task automatic goto_pc(input logic [31:0] target);
        clear_ctl();
        Jr = 1'b1; Read_data_1 = target;
        step();
        Jr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rom_data = 32'h8C43_0144; Addr_Result = 32'h0;
        Read_data_1 = 32'h0;
        clear_ctl();
        step();
        chk("reset_pc", PC, 32'h0);
        chk("reset_count", inst_count, 32'h0);
        chk("reset_link", link_addr, 32'h0);
        chk("reset_pc4", PC_plus_4, 32'h4);
        chk("reset_romadr", {18'h0, rom_adr}, 32'h0);

        reset = 1'b0;
        step(); chk("free_pc1", PC, 32'h4);
        step(); chk("free_pc2", PC, 32'h8);
        step(); chk("free_pc3", PC, 32'hC);
        step(); chk("free_pc4", PC, 32'h10);
        chk("free_count", inst_count, 32'd4);
        chk("free_link", link_addr, 32'h0);
        chk("free_romadr", {18'h0, rom_adr}, 32'h4);
        chk("fld_instr", Instruction, 32'h8C43_0144);
        chk("fld_exe", {26'h0, Exe_opcode}, 32'h23);
        chk("fld_func", {26'h0, Function_opcode}, 32'h04);
        chk("fld_shamt", {27'h0, Shamt}, 32'h5);

        goto_pc(32'h20);
        chk("jr_to_20", PC, 32'h20);
        Branch = 1'b1; Zero = 1'b1; Addr_Result = 32'h40;
        step(); chk("beq_taken", PC, 32'h40);

        goto_pc(32'h20);
        Branch = 1'b1; Zero = 1'b0; Addr_Result = 32'h40;
        step(); chk("beq_not_taken", PC, 32'h24);

        goto_pc(32'h20);
        nBranch = 1'b1; Zero = 1'b0; Addr_Result = 32'h40;
        step(); chk("bne_taken", PC, 32'h40);
        chk("count_after_br", inst_count, 32'd10);

        goto_pc(32'h1000_0010);
        rom_data = 32'h0C00_0100; Jal = 1'b1;
        step();
        chk("jal_pc", PC, 32'h1000_0400);
        chk("jal_link", link_addr, 32'h1000_0014);

        clear_ctl();
        Jr = 1'b1; Jmp = 1'b1; Read_data_1 = 32'h0000_0083;
        step();
        chk("jr_over_jmp", PC, 32'h80);
        chk("link_hold", link_addr, 32'h1000_0014);

        goto_pc(32'h8);
        stall = 1'b1; Branch = 1'b1; Zero = 1'b1; Addr_Result = 32'h100;
        step(); chk("stall_pc1", PC, 32'h8);
        step(); chk("stall_pc2", PC, 32'h8);
        step(); chk("stall_pc3", PC, 32'h8);
        chk("stall_count", inst_count, 32'd14);
        stall = 1'b0;
        step();
        chk("stall_release", PC, 32'h100);
        chk("release_count", inst_count, 32'd15);

        goto_pc(32'hFFFF_FFFC);
        chk("wrap_pc", PC, 32'hFFFF_FFFC);
        chk("wrap_pc4", PC_plus_4, 32'h0);
        chk("alias_romadr", {18'h0, rom_adr}, 32'h3FFF);
        step(); chk("wrap_next", PC, 32'h0);
        chk("wrap_next_pc4", PC_plus_4, 32'h4);
        step(); chk("pre_reset_pc", PC, 32'h4);

        reset = 1'b1; stall = 1'b1; Jr = 1'b1; Jal = 1'b1; Read_data_1 = 32'h200;
        step();
        chk("rst_stall_pc", PC, 32'h0);
        chk("rst_stall_count", inst_count, 32'h0);
        chk("rst_stall_link", link_addr, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
